// File: rtl/escalonador_tiros.sv
// Enemy fire scheduler: each period picks a pseudo-random living enemy and
// launches a bullet from it into the lowest free bullet slot.
module escalonador_tiros #(
   parameter int PERIODO_TICKS = 50000000,
   parameter int DESLOC_Y      = 35
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        pausa,
   input  logic        reiniciarJogo,
   input  logic [7:0]  inimigo_vivo,
   input  logic [79:0] inimigo_x,
   input  logic [79:0] inimigo_y,
   input  logic [3:0]  slot_livre,
   output logic [3:0]  disparo,
   output logic [9:0]  disparo_x,
   output logic [9:0]  disparo_y,
   output logic [2:0]  atirador,
   output logic [7:0]  perdidos,
   output logic [7:0]  lfsr_dbg
);

   localparam int             CW     = $clog2(PERIODO_TICKS);
   localparam logic [CW-1:0]  CARGA  = CW'(PERIODO_TICKS - 1);
   localparam logic [10:0]    DESLOC = 11'(DESLOC_Y);
   localparam logic [10:0]    Y_MAX  = 11'd479;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ESCOLHE = 2'd1,
      PROCURA = 2'd2,
      DISPARA = 2'd3
   } estado_t;

   // Fibonacci taps 8,6,5,4; the zero guard keeps the sequence alive after any upset.
   function automatic logic [7:0] lfsr_passo(input logic [7:0] v);
      logic [7:0] n;
      n = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      if (n == 8'h00) begin
         lfsr_passo = 8'hA5;
      end else begin
         lfsr_passo = n;
      end
   endfunction

   function automatic logic [7:0] soma_sat(input logic [7:0] v, input logic [1:0] inc);
      logic [8:0] s;
      s = {1'b0, v} + {7'd0, inc};
      if (s > 9'd255) begin
         soma_sat = 8'hFF;
      end else begin
         soma_sat = s[7:0];
      end
   endfunction

   estado_t       estado_q, estado_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pendente_q, pendente_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [2:0]    cand_q, cand_d;
   logic [2:0]    conta_q, conta_d;
   logic [9:0]    lat_x_q, lat_x_d;
   logic [9:0]    lat_y_q, lat_y_d;
   logic [2:0]    lat_idx_q, lat_idx_d;
   logic [3:0]    reserva_q, reserva_d;
   logic [2:0]    atirador_q, atirador_d;
   logic [7:0]    perdidos_q, perdidos_d;

   logic [3:0]    livre_s, escolha_s;
   logic [10:0]   y_soma_s;
   logic          pode_s, vivo_cand_s, tick_s, consome_s;
   logic [9:0]    cand_x_s, cand_y_s;
   logic [1:0]    inc_s;

   // Candidate enemy lookup, lowest free slot and spawn-height check.
   always_comb begin
      livre_s     = slot_livre & ~reserva_q;
      vivo_cand_s = inimigo_vivo[cand_q];
      cand_x_s    = inimigo_x[10*int'(cand_q) +: 10];
      cand_y_s    = inimigo_y[10*int'(cand_q) +: 10];
      if (livre_s[0]) begin
         escolha_s = 4'b0001;
      end else if (livre_s[1]) begin
         escolha_s = 4'b0010;
      end else if (livre_s[2]) begin
         escolha_s = 4'b0100;
      end else if (livre_s[3]) begin
         escolha_s = 4'b1000;
      end else begin
         escolha_s = 4'b0000;
      end
      y_soma_s = {1'b0, lat_y_q} + DESLOC;
      pode_s   = (livre_s != 4'd0) && (y_soma_s <= Y_MAX);
   end

   // The launch pulse lives for the single unpaused DISPARA cycle, so pausa gates it directly.
   always_comb begin
      disparo   = 4'd0;
      disparo_x = 10'd0;
      disparo_y = 10'd0;
      if ((estado_q == DISPARA) && !pausa && !reiniciarJogo && pode_s) begin
         disparo   = escolha_s;
         disparo_x = lat_x_q;
         disparo_y = y_soma_s[9:0];
      end else begin
         disparo   = 4'd0;
      end
   end

   // Next-state: period counter, LFSR, slot reservations and search FSM.
   always_comb begin
      estado_d   = estado_q;
      cnt_d      = cnt_q;
      pendente_d = pendente_q;
      lfsr_d     = lfsr_q;
      cand_d     = cand_q;
      conta_d    = conta_q;
      lat_x_d    = lat_x_q;
      lat_y_d    = lat_y_q;
      lat_idx_d  = lat_idx_q;
      reserva_d  = reserva_q;
      atirador_d = atirador_q;
      perdidos_d = perdidos_q;
      inc_s      = 2'd0;
      tick_s     = 1'b0;
      consome_s  = 1'b0;
      if (reiniciarJogo) begin
         estado_d   = OCIOSO;
         cnt_d      = CARGA;
         pendente_d = 1'b0;
         cand_d     = 3'd0;
         conta_d    = 3'd0;
         lat_x_d    = 10'd0;
         lat_y_d    = 10'd0;
         lat_idx_d  = 3'd0;
         reserva_d  = 4'd0;
         atirador_d = 3'd0;
         perdidos_d = 8'd0;
      end else if (pausa) begin
         estado_d = estado_q;
      end else begin
         lfsr_d    = lfsr_passo(lfsr_q);
         tick_s    = (cnt_q == {CW{1'b0}});
         consome_s = (estado_q == OCIOSO) && pendente_q;
         if (tick_s) begin
            cnt_d = CARGA;
         end else begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
         end
         pendente_d = tick_s | (pendente_q & ~consome_s);
         if (tick_s && pendente_q && !consome_s) begin
            inc_s = 2'd1;
         end else begin
            inc_s = 2'd0;
         end
         // A reservation holds only until its bullet is seen leaving park.
         reserva_d = reserva_q & slot_livre;
         case (estado_q)
            OCIOSO: begin
               if (pendente_q) begin
                  estado_d = ESCOLHE;
               end else begin
                  estado_d = OCIOSO;
               end
            end
            ESCOLHE: begin
               cand_d   = lfsr_q[2:0];
               conta_d  = 3'd0;
               estado_d = PROCURA;
            end
            PROCURA: begin
               if (vivo_cand_s) begin
                  lat_x_d   = cand_x_s;
                  lat_y_d   = cand_y_s;
                  lat_idx_d = cand_q;
                  estado_d  = DISPARA;
               end else if (conta_q == 3'd7) begin
                  inc_s    = inc_s + 2'd1;
                  estado_d = OCIOSO;
               end else begin
                  cand_d  = cand_q + 3'd1;
                  conta_d = conta_q + 3'd1;
               end
            end
            DISPARA: begin
               if (pode_s) begin
                  reserva_d  = reserva_d | escolha_s;
                  atirador_d = lat_idx_q;
               end else begin
                  inc_s = inc_s + 2'd1;
               end
               estado_d = OCIOSO;
            end
            default: begin
               estado_d = OCIOSO;
            end
         endcase
         perdidos_d = soma_sat(perdidos_q, inc_s);
      end
   end

   // State registers.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         estado_q   <= OCIOSO;
         cnt_q      <= CARGA;
         pendente_q <= 1'b0;
         lfsr_q     <= 8'hA5;
         cand_q     <= 3'd0;
         conta_q    <= 3'd0;
         lat_x_q    <= 10'd0;
         lat_y_q    <= 10'd0;
         lat_idx_q  <= 3'd0;
         reserva_q  <= 4'd0;
         atirador_q <= 3'd0;
         perdidos_q <= 8'd0;
      end else begin
         estado_q   <= estado_d;
         cnt_q      <= cnt_d;
         pendente_q <= pendente_d;
         lfsr_q     <= lfsr_d;
         cand_q     <= cand_d;
         conta_q    <= conta_d;
         lat_x_q    <= lat_x_d;
         lat_y_q    <= lat_y_d;
         lat_idx_q  <= lat_idx_d;
         reserva_q  <= reserva_d;
         atirador_q <= atirador_d;
         perdidos_q <= perdidos_d;
      end
   end

   assign atirador = atirador_q;
   assign perdidos = perdidos_q;
   assign lfsr_dbg = lfsr_q;

endmodule

// File: tb/tb_escalonador_tiros.sv
// Scoreboard bench for escalonador_tiros with PERIODO_TICKS=16: expected shots
// are queued ahead of time and a negedge monitor checks every pulse against them.
module tb_escalonador_tiros;

   localparam int P = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pausa = 1'b0;
   logic        reiniciarJogo = 1'b0;
   logic [7:0]  vivo = 8'hFF;
   logic [79:0] ix = 80'd0;
   logic [79:0] iy = 80'd0;
   logic [3:0]  livre = 4'hF;
   logic [3:0]  disparo;
   logic [9:0]  disparo_x, disparo_y;
   logic [2:0]  atirador;
   logic [7:0]  perdidos, lfsr_dbg;

   escalonador_tiros #(.PERIODO_TICKS(P), .DESLOC_Y(35)) dut (
      .CLOCK_50(clk), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
      .inimigo_vivo(vivo), .inimigo_x(ix), .inimigo_y(iy), .slot_livre(livre),
      .disparo(disparo), .disparo_x(disparo_x), .disparo_y(disparo_y),
      .atirador(atirador), .perdidos(perdidos), .lfsr_dbg(lfsr_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] slot;
      logic [9:0] x;
      logic [9:0] y;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   logic [9:0] ex[8];
   logic [9:0] ey[8];
   int         cyc = 0;
   int         base = 0;
   int         total = 0;
   int         bad = 0;
   int         last_idx = 0;
   bit         mon_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc - base);
      end
   endtask

   function automatic logic [7:0] lfsr_n(input int n);
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      return v;
   endfunction

   task automatic pack();
      for (int i = 0; i < 8; i++) begin
         ix[10*i +: 10] = ex[i];
         iy[10*i +: 10] = ey[i];
      end
   endtask

   // shifts = LFSR steps before the ESCOLHE cycle; pcyc = pulse cycle with no dead enemy skipped
   task automatic expect_shot(input int shifts, input int pcyc, input logic [3:0] slot);
      logic [7:0] l;
      int c, s;
      l = lfsr_n(shifts);
      c = int'(l[2:0]);
      s = 0;
      while (!vivo[c] && s < 8) begin
         c = (c + 1) % 8;
         s++;
      end
      q.push_back('{slot, ex[c], ey[c] + 10'd35, base + pcyc + s});
      last_idx = c;
   endtask

   task automatic at_cycle(input int n);
      while (cyc < base + n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      pausa = 1'b0;
      reiniciarJogo = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      base = cyc;
   endtask

   task automatic default_enemies();
      for (int i = 0; i < 8; i++) begin
         ex[i] = 10'(50 + 40 * i);
         ey[i] = 10'(10 + 20 * i);
      end
      pack();
   endtask

   // Monitor: every pulse must match the head of the queue; idle coords must be zero.
   always @(negedge clk) begin
      if (mon_on) begin
         if (disparo != 4'd0) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse", {28'd0, disparo}, 32'd0);
            end else begin
               mon_e = q.pop_front();
               chk("slot", {28'd0, disparo}, {28'd0, mon_e.slot});
               chk("disparo_x", {22'd0, disparo_x}, {22'd0, mon_e.x});
               chk("disparo_y", {22'd0, disparo_y}, {22'd0, mon_e.y});
               chk("pulse_cycle", cyc - base, mon_e.cyc - base);
            end
         end else begin
            chk("idle_x", {22'd0, disparo_x}, 32'd0);
            chk("idle_y", {22'd0, disparo_y}, 32'd0);
         end
      end
   end

   initial begin
      #1;
      default_enemies();
      reset = 1'b0;
      #1;
      mon_on = 1'b1;

      // All alive, all slots free: shots at 19 (slot 0) and 35 (slot 1).
      do_reset();
      chk("rst_perdidos", {24'd0, perdidos}, 32'd0);
      chk("rst_atirador", {29'd0, atirador}, 32'd0);
      chk("rst_lfsr", {24'd0, lfsr_dbg}, 32'hA5);
      chk("rst_disparo", {28'd0, disparo}, 32'd0);
      expect_shot(17, 19, 4'b0001);
      expect_shot(33, 35, 4'b0010);
      at_cycle(40);
      chk("s0_pending", q.size(), 32'd0);
      chk("s0_perdidos", {24'd0, perdidos}, 32'd0);
      chk("s0_atirador", {29'd0, atirador}, last_idx);

      // Reset in the middle of PROCURA suppresses the shot.
      do_reset();
      at_cycle(18);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Only enemy 5 alive at (200,40).
      vivo = 8'b0010_0000;
      ex[5] = 10'd200;
      ey[5] = 10'd40;
      pack();
      do_reset();
      expect_shot(17, 19, 4'b0001);
      at_cycle(30);
      chk("s2_pending", q.size(), 32'd0);
      chk("s2_atirador", {29'd0, atirador}, 32'd5);

      // Nobody alive for three periods.
      vivo = 8'h00;
      do_reset();
      at_cycle(60);
      chk("s3_perdidos", {24'd0, perdidos}, 32'd3);

      // No free slots, then slot 2 only, reservation held until it leaves park.
      default_enemies();
      vivo = 8'hFF;
      livre = 4'b0000;
      do_reset();
      at_cycle(40);
      chk("s4_perdidos_a", {24'd0, perdidos}, 32'd2);
      livre = 4'b0100;
      expect_shot(49, 51, 4'b0100);
      at_cycle(56);
      chk("s4_pending_a", q.size(), 32'd0);
      at_cycle(70);
      chk("s4_perdidos_b", {24'd0, perdidos}, 32'd3);
      livre = 4'b0000;
      at_cycle(72);
      livre = 4'b0100;
      expect_shot(81, 83, 4'b0100);
      at_cycle(90);
      chk("s4_pending_b", q.size(), 32'd0);
      chk("s4_perdidos_c", {24'd0, perdidos}, 32'd3);

      // Enemy 0 too low (450+35=485), then exactly at the edge (444+35=479).
      livre = 4'hF;
      vivo = 8'b0000_0001;
      ey[0] = 10'd450;
      pack();
      do_reset();
      at_cycle(46);
      chk("s5_perdidos", {24'd0, perdidos}, 32'd2);
      ey[0] = 10'd444;
      pack();
      expect_shot(49, 51, 4'b0001);
      at_cycle(62);
      chk("s5_pending", q.size(), 32'd0);
      chk("s5_perdidos_b", {24'd0, perdidos}, 32'd2);

      // Pause across DISPARA, then a restart clear under pause.
      default_enemies();
      vivo = 8'hFF;
      do_reset();
      expect_shot(17, 59, 4'b0001);
      at_cycle(19);
      pausa = 1'b1;
      at_cycle(20);
      chk("s6_lfsr_frozen_a", {24'd0, lfsr_dbg}, {24'd0, lfsr_n(19)});
      at_cycle(58);
      chk("s6_lfsr_frozen_b", {24'd0, lfsr_dbg}, {24'd0, lfsr_n(19)});
      at_cycle(59);
      pausa = 1'b0;
      expect_shot(33, 75, 4'b0010);
      at_cycle(80);
      chk("s6_pending", q.size(), 32'd0);
      livre = 4'b0000;
      at_cycle(95);
      chk("s6_perdidos", {24'd0, perdidos}, 32'd1);
      pausa = 1'b1;
      reiniciarJogo = 1'b1;
      at_cycle(96);
      reiniciarJogo = 1'b0;
      at_cycle(97);
      chk("s6_restart_perdidos", {24'd0, perdidos}, 32'd0);
      chk("s6_restart_atirador", {29'd0, atirador}, 32'd0);
      chk("s6_restart_lfsr", {24'd0, lfsr_dbg}, {24'd0, lfsr_n(55)});
      pausa = 1'b0;
      livre = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      chk("final_pending", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
